// File: rtl/full_logic_nch_pkg.sv
// Shared defaults and the channel-select width helpers.
// Latency: n/a (compile-time constants and functions only).
// Backpressure: n/a.
// Contents: default parameter values, ch_bits() = clog2(NUM_CH), route_width().
package full_logic_pkg;

  localparam int DEF_DATA_WIDTH    = 6;
  localparam int DEF_ADDRESS_WIDTH = 2;
  localparam int DEF_NUM_CH        = 2;
  localparam int DEF_AF_THRESH     = 3;
  localparam int DEF_AE_THRESH     = 1;

  // Number of top data bits that select the destination channel.
  function automatic int ch_bits(input int n);
    int b;
    b = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) b = i + 1;
    end
    return b;
  endfunction

  // Declared width of the route field; at least 1 so the signal always exists
  // even when a single channel needs no select bits.
  function automatic int route_width(input int n);
    return (ch_bits(n) == 0) ? 1 : ch_bits(n);
  endfunction

endpackage

// File: rtl/full_logic_nch_if.sv
// Bundle of the push/pop/status signals between a producer/consumer and full_logic_nch.
// Latency: n/a (wires only).
// Backpressure: in_full/pause flow upstream; per-channel empty gates pops.
// Ports: master drives wr_enable/data_in/pop; slave (the block) drives data_out and all status.
interface full_logic_nch_if
  import full_logic_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_CH     = DEF_NUM_CH
);

  logic                         wr_enable;
  logic [DATA_WIDTH-1:0]        data_in;
  logic [NUM_CH-1:0]            pop;
  logic [NUM_CH*DATA_WIDTH-1:0] data_out;
  logic [NUM_CH-1:0]            empty;
  logic [NUM_CH-1:0]            almost_empty;
  logic [NUM_CH-1:0]            almost_full;
  logic                         in_full;
  logic                         pause;
  logic [NUM_CH-1:0]            error;
  logic                         error_in;

  modport master (
    output wr_enable, data_in, pop,
    input  data_out, empty, almost_empty, almost_full, in_full, pause, error, error_in
  );

  modport slave (
    input  wr_enable, data_in, pop,
    output data_out, empty, almost_empty, almost_full, in_full, pause, error, error_in
  );

endinterface

// File: rtl/full_logic_nch_fifo_sync.sv
// Synchronous FIFO with combinational head word, occupancy count and threshold flags.
// Latency: pushed word is visible at head_dat the cycle after the push edge.
// Backpressure: push ignored while full, pop ignored while empty (caller decides policy).
// Ports: clk/reset, push+push_dat, pop, head_dat, count, full/empty/almost_full/almost_empty.
module fifo_sync
  import full_logic_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int AF_THRESH     = DEF_AF_THRESH,
  parameter int AE_THRESH     = DEF_AE_THRESH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [DATA_WIDTH-1:0]    push_dat,
  input  logic                     pop,
  output logic [DATA_WIDTH-1:0]    head_dat,
  output logic [ADDRESS_WIDTH:0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty
);

  localparam int DEPTH = 1 << ADDRESS_WIDTH;
  localparam int CW    = ADDRESS_WIDTH + 1;

  logic [DATA_WIDTH-1:0]    mem [DEPTH];
  logic [ADDRESS_WIDTH-1:0] wr_ptr;
  logic [ADDRESS_WIDTH-1:0] rd_ptr;
  logic                     push_ok;
  logic                     pop_ok;

  assign full         = (count == CW'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= CW'(AF_THRESH));
  assign almost_empty = (count <= CW'(AE_THRESH));

  assign push_ok  = push & ~full;
  assign pop_ok   = pop & ~empty;
  assign head_dat = mem[rd_ptr];

  // Storage carries no reset; validity is tracked purely by count.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_dat;
  end

  // Pointers are ADDRESS_WIDTH bits so they wrap modulo depth for free.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/full_logic_nch.sv
// One input FIFO demultiplexed by the word's top bits into NUM_CH output FIFOs.
// Latency: push at edge k -> output FIFO at k+1 -> data_out after the pop edge (k+2 earliest).
// Backpressure: blocked head stalls all later words; in_full drops pushes; pause = any almost_full.
// Ports: clk, reset (sync, active-high), bus (slave modport of full_logic_nch_if).
module full_logic_nch
  import full_logic_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int NUM_CH        = DEF_NUM_CH,
  parameter int AF_THRESH     = DEF_AF_THRESH,
  parameter int AE_THRESH     = DEF_AE_THRESH
) (
  input  logic                clk,
  input  logic                reset,
  full_logic_nch_if.slave     bus
);

  localparam int CH_BITS = ch_bits(NUM_CH);
  localparam int RW      = route_width(NUM_CH);
  localparam logic [RW:0] NUM_CH_V = (RW + 1)'(NUM_CH);

  // Input FIFO
  logic                   in_pop;
  logic [DATA_WIDTH-1:0]  in_head;
  logic                   in_empty;
  logic                   in_full_w;
  logic [ADDRESS_WIDTH:0] in_count_unused;
  logic                   in_af_unused;
  logic                   in_ae_unused;

  // Routing
  logic [RW-1:0]          route;
  logic                   route_bad;

  // Output FIFOs
  logic [NUM_CH-1:0]      out_push;
  logic [NUM_CH-1:0]      out_pop;
  logic [NUM_CH-1:0]      out_full;
  logic [NUM_CH-1:0]      out_empty;
  logic [NUM_CH-1:0]      out_af;
  logic [NUM_CH-1:0]      out_ae;
  logic [DATA_WIDTH-1:0]  out_head [NUM_CH];

  // Registered outputs
  logic [NUM_CH*DATA_WIDTH-1:0] data_out_q;
  logic [NUM_CH-1:0]            error_q;
  logic                         error_in_q;

  fifo_sync #(
    .DATA_WIDTH    (DATA_WIDTH),
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .AF_THRESH     (AF_THRESH),
    .AE_THRESH     (AE_THRESH)
  ) u_in_fifo (
    .clk          (clk),
    .reset        (reset),
    .push         (bus.wr_enable),
    .push_dat     (bus.data_in),
    .pop          (in_pop),
    .head_dat     (in_head),
    .count        (in_count_unused),
    .full         (in_full_w),
    .empty        (in_empty),
    .almost_full  (in_af_unused),
    .almost_empty (in_ae_unused)
  );

  generate
    if (NUM_CH == 1) begin : g_route_one
      assign route     = '0;
      assign route_bad = 1'b0;
    end else begin : g_route_multi
      assign route     = in_head[DATA_WIDTH-1 -: CH_BITS];
      // Only reachable when NUM_CH is not a power of two.
      assign route_bad = ({1'b0, route} >= NUM_CH_V);
    end
  endgenerate

  // Transfer decision uses start-of-cycle full flags only, so a same-cycle
  // pop on the destination never makes room for the head word.
  always_comb begin
    out_push = '0;
    in_pop   = 1'b0;
    if (!in_empty) begin
      if (route_bad) begin
        in_pop = 1'b1;
      end else begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (route == RW'(i) && !out_full[i]) begin
            out_push[i] = 1'b1;
            in_pop      = 1'b1;
          end
        end
      end
    end
  end

  assign out_pop = bus.pop & ~out_empty;

  generate
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      fifo_sync #(
        .DATA_WIDTH    (DATA_WIDTH),
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .AF_THRESH     (AF_THRESH),
        .AE_THRESH     (AE_THRESH)
      ) u_out_fifo (
        .clk          (clk),
        .reset        (reset),
        .push         (out_push[g]),
        .push_dat     (in_head),
        .pop          (out_pop[g]),
        .head_dat     (out_head[g]),
        .count        (),
        .full         (out_full[g]),
        .empty        (out_empty[g]),
        .almost_full  (out_af[g]),
        .almost_empty (out_ae[g])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      data_out_q <= '0;
      error_q    <= '0;
      error_in_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (bus.pop[i]) begin
          if (!out_empty[i]) data_out_q[i*DATA_WIDTH +: DATA_WIDTH] <= out_head[i];
          else               error_q[i] <= 1'b1;
        end
      end
      if ((bus.wr_enable && in_full_w) || (!in_empty && route_bad)) error_in_q <= 1'b1;
    end
  end

  assign bus.data_out     = data_out_q;
  assign bus.empty        = out_empty;
  assign bus.almost_empty = out_ae;
  assign bus.almost_full  = out_af;
  assign bus.in_full      = in_full_w;
  assign bus.pause        = |out_af;
  assign bus.error        = error_q;
  assign bus.error_in     = error_in_q;

endmodule
